// File: rtl/gpio_pkg.sv
// Shared GPIO_IN layout constants and the word-packing helper used by the input conditioner.
package gpio_pkg;

  localparam int GPIO_SW_LSB      = 0;
  localparam int GPIO_KEY_LSB     = 18;
  localparam int GPIO_USED_W      = 21;
  localparam int DEBOUNCE_DEFAULT = 500000;

  typedef logic [31:0] gpio_word_t;

  // Keys are stored at their raw (active-low) level, so they are inverted here to read pressed = 1.
  function automatic gpio_word_t pack_gpio(input logic [17:0] sw_level,
                                           input logic [2:0]  key_level_n);
    gpio_word_t word;
    word = '0;
    word[GPIO_SW_LSB +: 18] = sw_level;
    word[GPIO_KEY_LSB +: 3] = ~key_level_n;
    return word;
  endfunction

endpackage

// File: rtl/gpio_in_conditioner_debounce_bit.sv
// One conditioned input: 2-flop synchroniser followed by a stable-level debounce filter.
// rise pulses, coincident with the level update, whenever the level leaves RESET_LEVEL.
module debounce_bit
  import gpio_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter logic RESET_LEVEL     = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_reg;
  logic             s2_reg;
  logic             level_reg;
  logic             level_next;
  logic             rise_reg;
  logic             rise_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;

  // The counter only runs while the synchronised input disagrees with the stable level,
  // so any agreement restarts the qualification window and short glitches are dropped.
  always_comb begin
    cnt_next   = cnt_reg;
    level_next = level_reg;
    rise_next  = 1'b0;
    if (s2_reg == level_reg) begin
      cnt_next = '0;
    end else if (cnt_reg == CNT_MAX) begin
      level_next = s2_reg;
      cnt_next   = '0;
      rise_next  = (s2_reg != RESET_LEVEL);
    end else begin
      cnt_next = cnt_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_reg    <= RESET_LEVEL;
      s2_reg    <= RESET_LEVEL;
      level_reg <= RESET_LEVEL;
      rise_reg  <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      s1_reg    <= raw;
      s2_reg    <= s1_reg;
      level_reg <= level_next;
      rise_reg  <= rise_next;
      cnt_reg   <= cnt_next;
    end
  end

  assign level = level_reg;
  assign rise  = rise_reg;

endmodule

// File: rtl/gpio_in_conditioner.sv
// Conditions SW[17:0] and KEY[3:1] into the CPU GPIO_IN word, plus change and key-press strobes.
module gpio_in_conditioner
  import gpio_pkg::*;
#(
  parameter int NUM_SW          = 18,
  parameter int NUM_KEY         = 3,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SW-1:0]  sw_raw,
  input  logic [NUM_KEY-1:0] key_raw_n,
  output logic [31:0]        gpio_in,
  output logic               changed,
  output logic [NUM_KEY-1:0] key_press
);

  logic [NUM_SW-1:0]  sw_level;
  logic [NUM_SW-1:0]  sw_rise_unused;
  logic [NUM_KEY-1:0] key_level_n;
  logic [NUM_KEY-1:0] key_rise;
  gpio_word_t         gpio_word;
  gpio_word_t         gpio_prev_reg;
  logic               changed_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SW; gi++) begin : g_sw
      debounce_bit #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .RESET_LEVEL    (1'b0)
      ) u_db (
        .clk  (clk),
        .rst_n(rst_n),
        .raw  (sw_raw[gi]),
        .level(sw_level[gi]),
        .rise (sw_rise_unused[gi])
      );
    end
    // Keys rest high, so their "rise" fires on the released-to-pressed transition.
    for (gi = 0; gi < NUM_KEY; gi++) begin : g_key
      debounce_bit #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .RESET_LEVEL    (1'b1)
      ) u_db (
        .clk  (clk),
        .rst_n(rst_n),
        .raw  (key_raw_n[gi]),
        .level(key_level_n[gi]),
        .rise (key_rise[gi])
      );
    end
  endgenerate

  // gpio_in is a pure repack of the stable-level flops, so it carries no added latency.
  always_comb begin
    gpio_word = '0;
    gpio_word[GPIO_SW_LSB +: NUM_SW]   = sw_level;
    gpio_word[GPIO_KEY_LSB +: NUM_KEY] = ~key_level_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gpio_prev_reg <= '0;
      changed_reg   <= 1'b0;
    end else begin
      gpio_prev_reg <= gpio_word;
      changed_reg   <= (gpio_word != gpio_prev_reg);
    end
  end

  assign gpio_in   = gpio_word;
  assign changed   = changed_reg;
  assign key_press = key_rise;

endmodule

// File: tb/tb_gpio_in_conditioner.sv
// Directed bench for gpio_in_conditioner with DEBOUNCE_CYCLES=4 (update lands on edge 6, changed on edge 7).
module tb_gpio_in_conditioner;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [17:0] sw_raw;
  logic [2:0]  key_raw_n;
  logic [31:0] gpio_in;
  logic        changed;
  logic [2:0]  key_press;

  int errors = 0;
  int checks = 0;

  gpio_in_conditioner #(
    .NUM_SW         (18),
    .NUM_KEY        (3),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sw_raw   (sw_raw),
    .key_raw_n(key_raw_n),
    .gpio_in  (gpio_in),
    .changed  (changed),
    .key_press(key_press)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] g, input logic c, input logic [2:0] kp);
    chk({tag, ".gpio_in"}, gpio_in, g);
    chk({tag, ".changed"}, {31'b0, changed}, {31'b0, c});
    chk({tag, ".key_press"}, {29'b0, key_press}, {29'b0, kp});
  endtask

  task automatic settle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    rst_n     = 1'b0;
    sw_raw    = 18'h3FFFF;
    key_raw_n = 3'b111;

    // Reset held with switches high: outputs must stay at reset values.
    for (int k = 1; k <= 4; k++) begin
      step();
      chk_all($sformatf("reset_hold[%0d]", k), 32'h0, 1'b0, 3'b000);
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      step();
      chk_all($sformatf("reset_release[%0d]", k), (k >= 6) ? 32'h0003FFFF : 32'h0, (k == 7), 3'b000);
    end
    $display("txn reset_release gpio_in=%h", gpio_in);
    sw_raw = 18'h0;
    settle(10);
    chk_all("sw_clear", 32'h0, 1'b0, 3'b000);

    // Glitch of DEBOUNCE_CYCLES-1 cycles must be rejected.
    sw_raw = 18'h00001;
    settle(3);
    sw_raw = 18'h0;
    for (int k = 1; k <= 10; k++) begin
      step();
      chk_all($sformatf("glitch[%0d]", k), 32'h0, 1'b0, 3'b000);
    end
    $display("txn glitch gpio_in=%h", gpio_in);

    // Bounce in 2-cycle runs, then settle high on the final toggle.
    for (int t = 0; t < 8; t++) begin
      sw_raw = ((t / 2) % 2 == 0) ? 18'h00020 : 18'h0;
      step();
      chk_all($sformatf("bounce[%0d]", t), 32'h0, 1'b0, 3'b000);
    end
    sw_raw = 18'h00020;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk_all($sformatf("bounce_settle[%0d]", k), (k >= 6) ? 32'h20 : 32'h0, (k == 7), 3'b000);
    end
    $display("txn bounce gpio_in=%h", gpio_in);
    sw_raw = 18'h0;
    settle(10);
    chk_all("bounce_clear", 32'h0, 1'b0, 3'b000);

    // KEY[2] press held 20 cycles: one press pulse, then release without a pulse.
    key_raw_n = 3'b101;
    for (int k = 1; k <= 20; k++) begin
      step();
      chk_all($sformatf("key_press[%0d]", k), (k >= 6) ? 32'h00080000 : 32'h0, (k == 7),
              (k == 6) ? 3'b010 : 3'b000);
    end
    $display("txn key_press gpio_in=%h", gpio_in);
    key_raw_n = 3'b111;
    for (int k = 1; k <= 10; k++) begin
      step();
      chk_all($sformatf("key_release[%0d]", k), (k >= 6) ? 32'h0 : 32'h00080000, (k == 7), 3'b000);
    end
    $display("txn key_release gpio_in=%h", gpio_in);

    // Switches and KEY[1] applied together must land in the same cycle.
    sw_raw    = 18'h00055;
    key_raw_n = 3'b110;
    for (int k = 1; k <= 9; k++) begin
      step();
      chk_all($sformatf("simul[%0d]", k), (k >= 6) ? 32'h00040055 : 32'h0, (k == 7),
              (k == 6) ? 3'b001 : 3'b000);
    end
    $display("txn simultaneous gpio_in=%h", gpio_in);
    sw_raw    = 18'h0;
    key_raw_n = 3'b111;
    settle(10);
    chk_all("simul_clear", 32'h0, 1'b0, 3'b000);

    // Reset two cycles into a debounce clears outputs at once and restarts the latency.
    sw_raw = 18'h00002;
    settle(10);
    chk_all("pre_reset", 32'h2, 1'b0, 3'b000);
    sw_raw = 18'h0000A;
    settle(2);
    rst_n = 1'b0;
    #1;
    chk_all("reset_mid_immediate", 32'h0, 1'b0, 3'b000);
    settle(2);
    chk_all("reset_mid_hold", 32'h0, 1'b0, 3'b000);
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk_all($sformatf("reset_restart[%0d]", k), (k >= 6) ? 32'h0000000A : 32'h0, (k == 7), 3'b000);
    end
    $display("txn reset_mid gpio_in=%h", gpio_in);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
